mtsp_srcop_scheduler: RTL and testbench



---
 rtl/mtsp_srcop_pkg.sv | 24 ++
 rtl/mtsp_srcop_modifier.sv | 27 ++
 rtl/mtsp_srcop_scheduler.sv | 148 ++++++++++++++
 tb/tb_mtsp_srcop_scheduler.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mtsp_srcop_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mtsp_srcop_pkg
// Brief    : Shared op-field layout, FP24 bit positions and scheduler states
//            for the MTSP source-operand scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package mtsp_srcop_pkg;

    localparam int OP_W         = 2;
    localparam int SRCOP_SELECT = 0;
    localparam int SRCOP_NEGATE = 1;

    localparam int FP24_SIGN    = 23;
    localparam int FP24_EXP_MSB = 22;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } srcop_sched_state_t;

endpackage
`default_nettype wire

// File: rtl/mtsp_srcop_modifier.sv
`default_nettype none
// ============================================================================
// Module   : mtsp_srcop_modifier
// Brief    : Combinational source modifier: integer negate or FP24 sign flip.
// Revision : 1.0 - initial release
// ============================================================================
module mtsp_srcop_modifier
    import mtsp_srcop_pkg::*;
(
    input  logic [OP_W-1:0] i_op,
    input  logic [31:0]     i_src,
    output logic [31:0]     o_src
);

    always_comb begin
        if (i_op[SRCOP_SELECT]) begin
            o_src = i_op[SRCOP_NEGATE] ? (32'd0 - i_src) : i_src;
        end else begin
            // Only the FP24 sign moves; the upper byte rides along untouched.
            o_src = {i_src[31:FP24_SIGN+1],
                     i_src[FP24_SIGN] ^ i_op[SRCOP_NEGATE],
                     i_src[FP24_EXP_MSB:0]};
        end
    end

endmodule
`default_nettype wire

// File: rtl/mtsp_srcop_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : mtsp_srcop_scheduler
// Brief    : Sequences up to SRC_MAX source operands through one shared
//            modifier and returns the bundle over valid/ready.
//            Optional back-to-back accept: MTSP_SRCOP_SCHED_B2B_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mtsp_srcop_scheduler
    import mtsp_srcop_pkg::*;
#(
    parameter int SRC_MAX = 3
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     REQ_VALID,
    output logic                     REQ_READY,
    input  logic [1:0]               REQ_COUNT,
    input  logic [SRC_MAX*OP_W-1:0]  REQ_OP,
    input  logic [SRC_MAX*32-1:0]    REQ_SRC,
    output logic                     RSP_VALID,
    input  logic                     RSP_READY,
    output logic [1:0]               RSP_COUNT,
    output logic [SRC_MAX*32-1:0]    RSP_SRC,
    output logic                     BUSY
);

    srcop_sched_state_t          r_state;
    srcop_sched_state_t          w_next;
    logic [1:0]                  r_count;
    logic [1:0]                  r_idx;
    logic [SRC_MAX*OP_W-1:0]     r_op;
    logic [SRC_MAX*32-1:0]       r_src;
    logic [SRC_MAX*32-1:0]       r_res;
    logic                        w_req_ready;
    logic                        w_rsp_valid;
    logic                        w_busy;
    logic                        w_req_fire;
    logic                        w_rsp_fire;
    logic                        w_last;
    logic [OP_W-1:0]             w_mod_op;
    logic [31:0]                 w_mod_in;
    logic [31:0]                 w_mod_out;

    assign w_req_fire = REQ_VALID & w_req_ready;
    assign w_rsp_fire = w_rsp_valid & RSP_READY;
    assign w_last     = (r_idx == (r_count - 2'd1));

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_req_fire) begin
                    w_next = (REQ_COUNT == 2'd0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (w_last) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                if (w_rsp_fire) begin
                    w_next = IDLE;
`ifdef MTSP_SRCOP_SCHED_B2B_EN
                    if (w_req_fire) begin
                        w_next = (REQ_COUNT == 2'd0) ? DONE : ISSUE;
                    end
`endif
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_req_ready = 1'b0;
        w_rsp_valid = 1'b0;
        w_busy      = (r_state != IDLE);
        case (r_state)
            IDLE: w_req_ready = ~RST;
            DONE: begin
                w_rsp_valid = 1'b1;
`ifdef MTSP_SRCOP_SCHED_B2B_EN
                w_req_ready = ~RST & RSP_READY;
`endif
            end
            default: ;
        endcase
    end

    // One slot per ISSUE cycle feeds the single modifier instance.
    always_comb begin
        w_mod_op = '0;
        w_mod_in = '0;
        for (int i = 0; i < SRC_MAX; i++) begin
            if (r_idx == 2'(i)) begin
                w_mod_op = r_op[i*OP_W +: OP_W];
                w_mod_in = r_src[i*32 +: 32];
            end
        end
    end

    mtsp_srcop_modifier u_modifier (
        .i_op  (w_mod_op),
        .i_src (w_mod_in),
        .o_src (w_mod_out)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_count <= 2'd0;
            r_idx   <= 2'd0;
            r_op    <= '0;
            r_src   <= '0;
            r_res   <= '0;
        end else if (w_req_fire) begin
            r_count <= REQ_COUNT;
            r_idx   <= 2'd0;
            r_op    <= REQ_OP;
            r_src   <= REQ_SRC;
            r_res   <= '0;
        end else if (r_state == ISSUE) begin
            for (int i = 0; i < SRC_MAX; i++) begin
                if (r_idx == 2'(i)) begin
                    r_res[i*32 +: 32] <= w_mod_out;
                end
            end
            r_idx <= r_idx + 2'd1;
        end
    end

    assign REQ_READY = w_req_ready;
    assign RSP_VALID = w_rsp_valid;
    assign BUSY      = w_busy;
    assign RSP_COUNT = r_count;
    assign RSP_SRC   = r_res;

endmodule
`default_nettype wire

// File: tb/tb_mtsp_srcop_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_mtsp_srcop_scheduler
// Brief    : Self-checking bench for mtsp_srcop_scheduler against a bundle-level
//            reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mtsp_srcop_scheduler;

    logic        CLK;
    logic        RST;
    logic        REQ_VALID;
    logic        REQ_READY;
    logic [1:0]  REQ_COUNT;
    logic [5:0]  REQ_OP;
    logic [95:0] REQ_SRC;
    logic        RSP_VALID;
    logic        RSP_READY;
    logic [1:0]  RSP_COUNT;
    logic [95:0] RSP_SRC;
    logic        BUSY;

    int r_checks;
    int r_errors;

    mtsp_srcop_scheduler #(.SRC_MAX(3)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .REQ_VALID (REQ_VALID),
        .REQ_READY (REQ_READY),
        .REQ_COUNT (REQ_COUNT),
        .REQ_OP    (REQ_OP),
        .REQ_SRC   (REQ_SRC),
        .RSP_VALID (RSP_VALID),
        .RSP_READY (RSP_READY),
        .RSP_COUNT (RSP_COUNT),
        .RSP_SRC   (RSP_SRC),
        .BUSY      (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic t_check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        r_checks++;
        if (got !== exp) begin
            r_errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Bundle-level reference: each active slot is negated as an integer or
    // has its FP24 sign toggled; inactive slots are zero.
    function automatic logic [95:0] f_model(input logic [1:0] cnt, input logic [5:0] op,
                                            input logic [95:0] src);
        logic [95:0] res;
        res = '0;
        for (int i = 0; i < 3; i++) begin
            logic [31:0] s;
            logic        is_int;
            logic        neg;
            s      = src[i*32 +: 32];
            is_int = op[2*i];
            neg    = op[2*i+1];
            if (i < int'(cnt)) begin
                if (!neg)        res[i*32 +: 32] = s;
                else if (is_int) res[i*32 +: 32] = 32'(-longint'(s));
                else             res[i*32 +: 32] = s ^ 32'h0080_0000;
            end
        end
        return res;
    endfunction

    task automatic t_run_req(input logic [1:0] cnt, input logic [5:0] op,
                             input logic [95:0] src, input int hold);
        logic [95:0] exp_src;
        int          lat;
        int          wait_n;
        exp_src = f_model(cnt, op, src);
        wait_n  = 0;
        while (!REQ_READY && wait_n < 10) begin
            @(negedge CLK);
            wait_n++;
        end
        t_check("req_ready_before", REQ_READY, 1'b1);
        REQ_VALID = 1'b1;
        REQ_COUNT = cnt;
        REQ_OP    = op;
        REQ_SRC   = src;
        @(negedge CLK);
        REQ_VALID = 1'b0;
        REQ_SRC   = $urandom();
        lat = 1;
        while (!RSP_VALID && lat < 20) begin
            @(negedge CLK);
            lat++;
        end
        t_check("latency", 96'(lat), 96'((cnt == 2'd0) ? 1 : int'(cnt) + 1));
        t_check("rsp_count", RSP_COUNT, cnt);
        t_check("rsp_src", RSP_SRC, exp_src);
        for (int h = 0; h < hold; h++) begin
            REQ_VALID = 1'b1;
            REQ_COUNT = 2'($urandom_range(0, 3));
            REQ_OP    = 6'($urandom());
            @(negedge CLK);
            t_check("hold_valid", RSP_VALID, 1'b1);
            t_check("hold_req_ready", REQ_READY, 1'b0);
            t_check("hold_src", RSP_SRC, exp_src);
            t_check("hold_count", RSP_COUNT, cnt);
        end
        REQ_VALID = 1'b0;
        RSP_READY = 1'b1;
        @(negedge CLK);
        RSP_READY = 1'b0;
        t_check("post_rsp_valid", RSP_VALID, 1'b0);
        t_check("post_busy", BUSY, 1'b0);
        t_check("post_req_ready", REQ_READY, 1'b1);
    endtask

    initial begin
        int          seen;
        int          last_t;
        int          gaps_ok;
        logic [1:0]  cnt;
        r_checks  = 0;
        r_errors  = 0;
        RST       = 1'b1;
        REQ_VALID = 1'b0;
        REQ_COUNT = 2'd0;
        REQ_OP    = '0;
        REQ_SRC   = '0;
        RSP_READY = 1'b0;
        repeat (2) @(negedge CLK);
        t_check("rst_req_ready", REQ_READY, 1'b0);
        t_check("rst_rsp_valid", RSP_VALID, 1'b0);
        t_check("rst_busy", BUSY, 1'b0);
        t_check("rst_rsp_src", RSP_SRC, 96'd0);
        t_check("rst_rsp_count", RSP_COUNT, 2'd0);
        RST = 1'b0;
        @(negedge CLK);
        t_check("rel_req_ready", REQ_READY, 1'b1);

        t_run_req(2'd3, 6'b11_11_11, {32'h8000_0000, 32'hFFFF_FFFF, 32'd5}, 0);
        t_run_req(2'd2, 6'b11_00_10, {32'h1234_5678, 32'h00BF_0000, 32'hAB3F_8000}, 0);
        t_run_req(2'd0, 6'b11_11_11, {32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h0BAD_F00D}, 0);
        t_run_req(2'd3, 6'b01_10_11, {32'd0, 32'h0080_0000, 32'h0000_0001}, 5);

        for (int n = 0; n < 40; n++) begin
            t_run_req(2'($urandom_range(0, 3)), 6'($urandom()),
                      {32'($urandom()), 32'($urandom()), 32'($urandom())},
                      int'($urandom_range(0, 3)));
        end

        // Abort on the second ISSUE cycle of a three-operand bundle.
        REQ_VALID = 1'b1;
        REQ_COUNT = 2'd3;
        REQ_OP    = 6'b11_11_11;
        REQ_SRC   = {32'd3, 32'd2, 32'd1};
        @(negedge CLK);
        REQ_VALID = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        t_check("abort_rsp_valid", RSP_VALID, 1'b0);
        t_check("abort_busy", BUSY, 1'b0);
        t_check("abort_rsp_src", RSP_SRC, 96'd0);
        t_check("abort_rsp_count", RSP_COUNT, 2'd0);
        RST = 1'b0;
        @(negedge CLK);
        t_check("abort_req_ready", REQ_READY, 1'b1);
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            if (RSP_VALID) seen++;
            @(negedge CLK);
        end
        t_check("abort_no_rsp", 96'(seen), 96'd0);

        // Streaming single-operand requests with the sink always ready.
        cnt       = 2'd1;
        REQ_VALID = 1'b1;
        REQ_COUNT = cnt;
        REQ_OP    = 6'b00_00_11;
        REQ_SRC   = {32'd0, 32'd0, 32'd7};
        RSP_READY = 1'b1;
        seen      = 0;
        last_t    = -1;
        gaps_ok   = 1;
        for (int t = 0; t < 24; t++) begin
            @(negedge CLK);
            if (RSP_VALID) begin
                t_check("stream_src", RSP_SRC, f_model(cnt, REQ_OP, REQ_SRC));
                if (last_t >= 0) begin
`ifdef MTSP_SRCOP_SCHED_B2B_EN
                    t_check("stream_gap", 96'(t - last_t), 96'd2);
`else
                    t_check("stream_gap", 96'(t - last_t), 96'd3);
`endif
                end
                last_t = t;
                seen++;
            end
        end
        t_check("stream_seen_some", 96'(seen >= 6), 96'd1);
        REQ_VALID = 1'b0;
        repeat (4) @(negedge CLK);
        RSP_READY = 1'b0;
        t_check("stream_idle", BUSY, 1'b0);

        $display("CHECKS %0d ERRORS %0d", r_checks, r_errors);
        $finish;
    end

endmodule
`default_nettype wire
